// File: rtl/mag_compare_seq.sv
// Sequential magnitude comparator: one DIGIT-bit slice per clock, MS slice first, start/done handshake.
// Define MAG_COMPARE_EARLY_EXIT_EN to stop on the first differing slice.
module mag_compare_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4,
    parameter bit SIGNED = 1'b0,
    localparam int D = WIDTH / DIGIT,
    localparam int CW = $clog2(D + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AeB,
    output logic             AiB,
    output logic             AsB,
    output logic [CW-1:0]    digits
);

`ifdef MAG_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             found;
    logic             found_lt;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic             slice_diff;
    logic             slice_lt;
    logic             last_slice;
    logic             finish;

    // Offset binary: flipping both sign bits turns a signed compare into an unsigned one.
    always_comb begin
        a_cap = A;
        b_cap = B;
        if (SIGNED) begin
            a_cap[WIDTH-1] = ~A[WIDTH-1];
            b_cap[WIDTH-1] = ~B[WIDTH-1];
        end
    end

    assign slice_a    = a_sh[WIDTH-1 -: DIGIT];
    assign slice_b    = b_sh[WIDTH-1 -: DIGIT];
    assign slice_diff = (slice_a != slice_b);
    assign slice_lt   = (slice_a < slice_b);
    assign last_slice = (cnt == CW'(D - 1));
    assign finish     = last_slice || (EARLY_EXIT && slice_diff);

    assign busy = (state == CMP);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CMP;
            CMP:     if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first differing slice is remembered so later slices cannot overwrite the verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            found    <= 1'b0;
            found_lt <= 1'b0;
            AeB      <= 1'b0;
            AiB      <= 1'b0;
            AsB      <= 1'b0;
            digits   <= '0;
        end else if (state == IDLE && start) begin
            a_sh     <= a_cap;
            b_sh     <= b_cap;
            cnt      <= '0;
            found    <= 1'b0;
            found_lt <= 1'b0;
            AeB      <= 1'b0;
            AiB      <= 1'b0;
            AsB      <= 1'b0;
            digits   <= '0;
        end else if (state == CMP) begin
            a_sh <= a_sh << DIGIT;
            b_sh <= b_sh << DIGIT;
            cnt  <= cnt + CW'(1);
            if (slice_diff && !found) begin
                found    <= 1'b1;
                found_lt <= slice_lt;
            end
            if (finish) begin
                digits <= cnt + CW'(1);
                if (found) begin
                    AiB <= found_lt;
                    AsB <= ~found_lt;
                end else if (slice_diff) begin
                    AiB <= slice_lt;
                    AsB <= ~slice_lt;
                end else begin
                    AeB <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mag_compare_seq.sv
// Bench for mag_compare_seq: 16/4 and 4/1 configurations, unsigned and signed, scoreboard-checked.
module tb_mag_compare_seq;

`ifdef MAG_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // pair 0: WIDTH=16 DIGIT=4, pair 1: WIDTH=4 DIGIT=1; index s: 0 unsigned, 1 signed
    logic        start_v [2];
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy_o  [2][2];
    logic        done_o  [2][2];
    logic        aeb_o   [2][2];
    logic        aib_o   [2][2];
    logic        asb_o   [2][2];
    logic [2:0]  dig_o   [2][2];

    mag_compare_seq #(.WIDTH(16), .DIGIT(4), .SIGNED(1'b0)) u_w16_u (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in),
        .busy(busy_o[0][0]), .done(done_o[0][0]), .AeB(aeb_o[0][0]),
        .AiB(aib_o[0][0]), .AsB(asb_o[0][0]), .digits(dig_o[0][0]));

    mag_compare_seq #(.WIDTH(16), .DIGIT(4), .SIGNED(1'b1)) u_w16_s (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a_in), .B(b_in),
        .busy(busy_o[0][1]), .done(done_o[0][1]), .AeB(aeb_o[0][1]),
        .AiB(aib_o[0][1]), .AsB(asb_o[0][1]), .digits(dig_o[0][1]));

    mag_compare_seq #(.WIDTH(4), .DIGIT(1), .SIGNED(1'b0)) u_w4_u (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in[3:0]), .B(b_in[3:0]),
        .busy(busy_o[1][0]), .done(done_o[1][0]), .AeB(aeb_o[1][0]),
        .AiB(aib_o[1][0]), .AsB(asb_o[1][0]), .digits(dig_o[1][0]));

    mag_compare_seq #(.WIDTH(4), .DIGIT(1), .SIGNED(1'b1)) u_w4_s (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a_in[3:0]), .B(b_in[3:0]),
        .busy(busy_o[1][1]), .done(done_o[1][1]), .AeB(aeb_o[1][1]),
        .AiB(aib_o[1][1]), .AsB(asb_o[1][1]), .digits(dig_o[1][1]));

    // ---------------- scoreboard ----------------
    // entry: {AeB, AiB, AsB, digits[2:0], latency[7:0]}
    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] model(input int p, input int s, input logic [15:0] a,
                                          input logic [15:0] b);
        int w;
        int dig;
        int av;
        int bv;
        int n;
        int sh;
        bit hit;
        logic [2:0] flags;
        w   = (p != 0) ? 4 : 16;
        dig = (p != 0) ? 1 : 4;
        av  = int'(a) & ((1 << w) - 1);
        bv  = int'(b) & ((1 << w) - 1);
        if (s != 0) begin
            if (av >= (1 << (w - 1))) av -= (1 << w);
            if (bv >= (1 << (w - 1))) bv -= (1 << w);
        end
        if (av == bv)     flags = 3'b100;
        else if (av < bv) flags = 3'b010;
        else              flags = 3'b001;
        n = 4;
        hit = 1'b0;
        if (EARLY) begin
            for (int k = 0; k < 4; k++) begin
                sh = w - dig * (k + 1);
                if (!hit && ((((int'(a) >> sh) ^ (int'(b) >> sh)) & ((1 << dig) - 1)) != 0)) begin
                    n = k + 1;
                    hit = 1'b1;
                end
            end
        end
        return {flags, 3'(n), 8'(n + 1)};
    endfunction

    function automatic logic [2:0] flags_of(input int p, input int s);
        return {aeb_o[p][s], aib_o[p][s], asb_o[p][s]};
    endfunction

    // ---------------- driver tasks ----------------
    // One compare on pair p; random start pulses and operand churn while busy must be ignored.
    task automatic run_cmp(input int p, input logic [15:0] a, input logic [15:0] b);
        logic [13:0] e [2];
        int  lat;
        bit  seen;
        @(negedge clk);
        a_in = a;
        b_in = b;
        start_v[p] = 1'b1;
        for (int s = 0; s < 2; s++) exp_q.push_back(model(p, s, a, b));
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                for (int s = 0; s < 2; s++) begin
                    check("busy_after_accept", 32'(busy_o[p][s]), 32'd1);
                    check("cleared_after_accept", 32'({flags_of(p, s), dig_o[p][s]}), 32'd0);
                end
            end
            if (done_o[p][0] || done_o[p][1]) begin
                seen = 1'b1;
                start_v[p] = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    e[s] = exp_q.pop_front();
                    check("done", 32'(done_o[p][s]), 32'd1);
                    check("busy_in_done", 32'(busy_o[p][s]), 32'd0);
                    check("flags", 32'(flags_of(p, s)), 32'(e[s][13:11]));
                    check("digits", 32'(dig_o[p][s]), 32'(e[s][10:8]));
                    check("latency", 32'(lat), 32'(e[s][7:0]));
                end
            end else begin
                start_v[p] = 1'($urandom_range(0, 1));
                a_in = 16'($urandom);
                b_in = 16'($urandom);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            start_v[p] = 1'b0;
            exp_q.delete();
        end else begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check("done_one_cycle", 32'(done_o[p][s]), 32'd0);
                check("flags_hold", 32'({flags_of(p, s), dig_o[p][s]}), 32'({e[s][13:11], e[s][10:8]}));
            end
        end
    endtask

    // start held high: accepts must be exactly N+2 cycles apart, one done each.
    task automatic handshake_test();
        logic [13:0] e;
        int cyc;
        int ndone;
        int last;
        @(negedge clk);
        a_in = 16'h0010;
        b_in = 16'h0001;
        start_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(0, 0, 16'h0010, 16'h0001));
        cyc = 0;
        ndone = 0;
        last = 0;
        while (ndone < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done_o[0][0]) begin
                e = exp_q.pop_front();
                check("hs_flags", 32'(flags_of(0, 0)), 32'(e[13:11]));
                check("hs_digits", 32'(dig_o[0][0]), 32'(e[10:8]));
                if (ndone == 0) check("hs_first_latency", 32'(cyc), 32'(e[7:0]));
                else            check("hs_period", 32'(cyc - last), 32'(int'(e[10:8]) + 2));
                last = cyc;
                ndone++;
                if (ndone == 3) start_v[0] = 1'b0;
            end
        end
        if (ndone < 3) begin
            check("hs_timeout", 32'(ndone), 32'd3);
            start_v[0] = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
        check("hs_idle_after", 32'({busy_o[0][0], done_o[0][0]}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag, input int p);
        for (int s = 0; s < 2; s++)
            check(tag, 32'({busy_o[p][s], done_o[p][s], flags_of(p, s), dig_o[p][s]}), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state", 0);
        check_all_zero("reset_state", 1);
        rst = 1'b0;

        run_cmp(0, 16'h8000, 16'h7FFF);
        run_cmp(0, 16'hBEEF, 16'hBEEF);
        run_cmp(0, 16'hBEEE, 16'hBEEF);
        run_cmp(0, 16'h8000, 16'h0001);
        run_cmp(0, 16'hFFFF, 16'hFFFE);
        run_cmp(0, 16'h0000, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            run_cmp(0, ra, ra ^ (16'h0001 << $urandom_range(0, 15)));
            run_cmp(0, 16'($urandom), 16'($urandom));
        end

        // reset in the second CMP cycle
        @(negedge clk);
        a_in = 16'h1234;
        b_in = 16'h1235;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("busy_before_reset", 32'(busy_o[0][0]), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_cmp", 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmp(0, 16'h0000, 16'h0000);

        handshake_test();

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_cmp(1, 16'(a), 16'(b));

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mag_compare_seq.md
# mag_compare_seq

Parametrised, sequential successor to the team's 4-bit combinational magnitude comparator: compares two WIDTH-bit operands one DIGIT-bit slice per clock, most-significant slice first. Returns one-hot equal / inferior / superior flags through a start/done handshake. Optional early exit stops on the first differing slice, so the remaining slices cost no switching energy. Sits in the low-power datapath wherever a wide compare can tolerate multi-cycle latency.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare.
- Derived: D = WIDTH/DIGIT slices; CW = clog2(D+1).
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only when busy = 0.
- A  input  WIDTH  operand A; captured on the accepting edge.
- B  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse when the result flags become valid.
- AeB  output  1  A equals B.
- AiB  output  1  A is inferior to B (A < B).
- AsB  output  1  A is superior to B (A > B).
- digits  output  CW  number of slices examined for the last result.

## Operation
- States: IDLE, CMP, DONE.
- IDLE, start = 1 → capture A and B into shift registers.
  - SIGNED = 1: the MSB of both captured operands is inverted (offset binary), after which the compare is unsigned.
  - Clear AeB/AiB/AsB/digits to 0, set busy, go to CMP with slice index 0.
- CMP: each cycle, compare the top DIGIT bits of both shift registers, shift both left by DIGIT, increment digits.
  - Slices unequal → latch AiB/AsB from that slice (first difference wins).
  - Slices equal and last slice → AeB = 1.
  - Go to DONE after the deciding slice. The deciding slice is the first difference with early exit, and always the last slice without.
- DONE: done = 1, busy = 0 for one cycle, then IDLE.
- Flags and digits hold until the next accepted start.
- After done, exactly one of AeB/AiB/AsB is 1.
- start while busy = 1 or in DONE: ignored; not queued.
- A/B changes after the accepting edge have no effect.
- Reset (any state, including mid-CMP): IDLE immediately.
  - All outputs 0: busy, done, AeB, AiB, AsB, digits.
  - Shift registers need not be cleared.

## Timing
- Accepting edge = edge E0. busy is high from E0 until the edge that asserts done.
- Slice k (0 = MS) is evaluated in cycle k+1 after E0.
- done is high during cycle N+1 after E0, where N = digits examined.
  - Early exit: N = index of first differing slice + 1, or D if the operands are equal.
  - Otherwise: N = D always, including when A ≠ B.
- Back-to-back throughput: a new start is accepted earliest in the cycle after done (IDLE). Minimum period N+2 cycles.
- Flags and digits are registered and change only on the edge entering DONE, on the accepting edge (cleared), or on reset.

## Configuration
- MAG_COMPARE_EARLY_EXIT_EN
  - Defined: CMP terminates on the first differing slice. Latency is data dependent (1..D slices); unused slices are never shifted or compared.
  - Undefined: all D slices are always shifted and compared; latency is fixed at D. First-difference result is unchanged.
  - Flag values are identical in both builds; only done timing and digits differ.

## Test plan
- Reset mid-CMP: WIDTH=16, DIGIT=4, start with A=0x1234, B=0x1235; assert rst in the 2nd CMP cycle → all outputs 0 at once; a later start with A=B=0x0000 completes with AeB=1, digits=4.
- Unsigned early exit (macro defined): A=0x8000, B=0x7FFF → AsB=1, digits=1, done 2 cycles after E0. Same stimulus without the macro → AsB=1, digits=4, done 5 cycles after E0.
- Equal and LSB difference: A=B=0xBEEF → AeB=1, digits=4. A=0xBEEE, B=0xBEEF → AiB=1, digits=4 in both builds.
- Signed: SIGNED=1, A=0x8000 (−32768), B=0x0001 → AiB=1. A=0xFFFF (−1), B=0xFFFE (−2) → AsB=1.
- Handshake: start held high continuously with A=0x0010, B=0x0001 → exactly one done per accept, new accept only in the IDLE cycle after done; start pulses during busy are ignored; one-hot flags hold between dones.
- Exhaustive sweep: WIDTH=4, DIGIT=1, all 256 A/B pairs, both SIGNED values, both builds → flags match a reference compare; digits = 4 without the macro.
